// File: rtl/rs_dsp_macc_pipe.sv
// rs_dsp_macc_pipe: pipelined signed/unsigned multiply-accumulate with round/shift/saturate output
module rs_dsp_macc_pipe #(
  parameter int A_WIDTH   = 20,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 64,
  parameter int OUT_WIDTH = 38,
  parameter int IN_REG    = 1,
  parameter int OUT_REG   = 1
) (
  input  logic                 clk,
  input  logic                 lreset,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 unsigned_a,
  input  logic                 unsigned_b,
  input  logic                 load_acc,
  input  logic                 subtract,
  input  logic [5:0]           shift_right,
  input  logic                 round,
  input  logic                 saturate_enable,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] z,
  output logic                 overflow
);
  localparam int W1 = ACC_WIDTH + 1;
  logic [11:0] ctl_in, ctl_r, ctl_i;
  logic [A_WIDTH-1:0] a_r, a_i;
  logic [B_WIDTH-1:0] b_r, b_i;
  logic v_r, v_i, v_m, v_a, v_o;
  logic signed [A_WIDTH:0] ea;
  logic signed [B_WIDTH:0] eb;
  logic signed [ACC_WIDTH-1:0] p_c, p_m, d;
  logic [ACC_WIDTH-1:0] acc;
  logic [9:0] ctl_m;
  logic [7:0] post_a;
  logic [5:0] sh;
  logic signed [ACC_WIDTH:0] t, s;
  logic fits, ov_o;
  logic [OUT_WIDTH-1:0] z_c, z_o;
  assign ctl_in = {unsigned_a, unsigned_b, load_acc, subtract, shift_right, round, saturate_enable};
  // Stage I: optional input register, bypassed when IN_REG is 0
  always_ff @(posedge clk) begin
    if (lreset) v_r <= 1'b0;
    else v_r <= in_valid;
    a_r <= a;
    b_r <= b;
    ctl_r <= ctl_in;
  end
  assign v_i   = IN_REG != 0 ? v_r : in_valid;
  assign a_i   = IN_REG != 0 ? a_r : a;
  assign b_i   = IN_REG != 0 ? b_r : b;
  assign ctl_i = IN_REG != 0 ? ctl_r : ctl_in;
  // Extend each operand by one bit so signed and unsigned both multiply as signed
  always_comb begin
    ea = {~ctl_i[11] & a_i[A_WIDTH-1], a_i};
    eb = {~ctl_i[10] & b_i[B_WIDTH-1], b_i};
    p_c = ACC_WIDTH'(ea) * ACC_WIDTH'(eb);
  end
  // Stage M: product register with its sample's controls
  always_ff @(posedge clk) begin
    if (lreset) v_m <= 1'b0;
    else v_m <= v_i;
    p_m <= p_c;
    ctl_m <= ctl_i[9:0];
  end
  assign d = ctl_m[8] ? -p_m : p_m;
  // Stage A: accumulator and output controls only advance on valid samples
  always_ff @(posedge clk) begin
    if (lreset) begin
      v_a <= 1'b0;
      acc <= '0;
      post_a <= '0;
    end else begin
      v_a <= v_m;
      if (v_m) begin
        acc <= ctl_m[9] ? d : acc + d;
        post_a <= ctl_m[7:0];
      end
    end
  end
  assign sh = post_a[7:2];
  // Round in one extra bit so the bias cannot wrap, then shift and range-check
  always_comb begin
    t = {acc[ACC_WIDTH-1], acc} + ((post_a[1] && sh != 6'd0) ? (W1'(1) << (sh - 6'd1)) : '0);
    s = t >>> sh;
    fits = &s[ACC_WIDTH:OUT_WIDTH-1] | ~|s[ACC_WIDTH:OUT_WIDTH-1];
    z_c = (!fits && post_a[0]) ? (s[ACC_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}}) : s[OUT_WIDTH-1:0];
  end
  // Stage O: optional output register, holds the last result between pulses
  always_ff @(posedge clk) begin
    if (lreset) begin
      v_o <= 1'b0;
      z_o <= '0;
      ov_o <= 1'b0;
    end else begin
      v_o <= v_a;
      if (v_a) begin
        z_o <= z_c;
        ov_o <= ~fits;
      end
    end
  end
  assign out_valid = OUT_REG != 0 ? v_o : v_a;
  assign z         = OUT_REG != 0 ? z_o : z_c;
  assign overflow  = OUT_REG != 0 ? ov_o : ~fits;
endmodule
